wb_tx_stream_fifo: RTL and testbench

- Wishbone slave that sits directly downstream of the AHB-to-FPGA bridge, alongside the FPGA register block.
- Software writes 32-bit words into a local circular buffer. The block drains them onto a valid/ready stream toward a downstream datapath consumer.
- Provides a status register, control register, low-watermark interrupt and a sticky overflow flag so firmware can refill without polling.

---
 rtl/wb_tx_stream_fifo.sv | 141 ++++++++++++++
 tb/tb_wb_tx_stream_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_tx_stream_fifo.sv
// Wishbone-fed circular word buffer drained onto a valid/ready stream.
// Status/control registers, low-watermark interrupt and sticky overflow for firmware refill.
module wb_tx_stream_fifo #(
  parameter int                   ADDRWIDTH     = 9,
  parameter int                   DATAWIDTH     = 32,
  parameter int                   DEPTH         = 16,
  parameter int                   PTRW          = 4,
  parameter logic [ADDRWIDTH-1:0] BASE_ADR      = 9'h0C0,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic [DATAWIDTH-1:0] M_DATA_o,
  output logic                 M_VALID_o,
  input  logic                 M_READY_i,
  output logic                 IRQ_o
);

  localparam int                   CW         = PTRW + 1;
  localparam logic [CW-1:0]        FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0]        AFULL_CNT  = CW'(DEPTH - 1);
  localparam logic [ADDRWIDTH-1:0] STATUS_ADR = BASE_ADR + ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] CTRL_ADR   = BASE_ADR + ADDRWIDTH'(2);

  logic                 ack_q;
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 enable_q, enable_d, irq_en_q, irq_en_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [7:0]           lwm_q, lwm_d;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic acc, wr, hit_data, hit_status, hit_ctrl;
  logic full, empty, push, pop, ovf_evt, ctrl_b0, ctrl_b1, flush;
  logic [DATAWIDTH-1:0] status_rd, ctrl_rd;
  logic [1:0] unused_bstb;

  assign unused_bstb = WBs_BYTE_STB_i[3:2];

  always_comb begin
    acc        = WBs_CYC_i & WBs_STB_i & ~ack_q;
    wr         = acc & WBs_WE_i;
    hit_data   = (WBs_ADR_i == BASE_ADR);
    hit_status = (WBs_ADR_i == STATUS_ADR);
    hit_ctrl   = (WBs_ADR_i == CTRL_ADR);
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    M_VALID_o  = enable_q & ~empty;
    pop        = M_VALID_o & M_READY_i;
    // Fullness is judged on the registered count, so a concurrent pop never rescues a push.
    push       = wr & hit_data & ~full;
    ovf_evt    = wr & hit_data & full;
    ctrl_b0    = wr & hit_ctrl & WBs_BYTE_STB_i[0];
    ctrl_b1    = wr & hit_ctrl & WBs_BYTE_STB_i[1];
    flush      = ctrl_b0 & WBs_DAT_i[1];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    lwm_d    = lwm_q;
    ovf_d    = ovf_q;
    if (ctrl_b0) begin
      enable_d = WBs_DAT_i[0];
      irq_en_d = WBs_DAT_i[2];
    end
    if (ctrl_b1) lwm_d = WBs_DAT_i[15:8];
    if (wr & hit_status & WBs_BYTE_STB_i[0] & WBs_DAT_i[3]) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    irq_d = irq_en_d & ((9'(count_d) <= 9'(lwm_d)) | ovf_d);
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      lwm_q    <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= acc;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      lwm_q    <= lwm_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (push) mem_q[wr_ptr_q] <= WBs_DAT_i;
  end

  always_comb begin
    status_rd        = '0;
    status_rd[0]     = empty;
    status_rd[1]     = full;
    status_rd[2]     = (count_q >= AFULL_CNT);
    status_rd[3]     = ovf_q;
    status_rd[15:8]  = 8'(count_q);
    ctrl_rd          = '0;
    ctrl_rd[0]       = enable_q;
    ctrl_rd[2]       = irq_en_q;
    ctrl_rd[15:8]    = lwm_q;
    if (hit_data)        WBs_DAT_o = '0;
    else if (hit_status) WBs_DAT_o = status_rd;
    else if (hit_ctrl)   WBs_DAT_o = ctrl_rd;
    else                 WBs_DAT_o = DEF_REG_VALUE;
  end

  assign WBs_ACK_o = ack_q;
  assign M_DATA_o  = mem_q[rd_ptr_q];
  assign IRQ_o     = irq_q;

endmodule

// File: tb/tb_wb_tx_stream_fifo.sv
// Directed bench for wb_tx_stream_fifo: register access, stream ordering, overflow,
// wrap-around, low-watermark interrupt, flush and asynchronous reset.
module tb_wb_tx_stream_fifo;

  localparam logic [8:0] A_DATA = 9'h0C0;
  localparam logic [8:0] A_STAT = 9'h0C1;
  localparam logic [8:0] A_CTRL = 9'h0C2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  adr = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  bstb = 4'h0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_tx_stream_fifo dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(bstb), .WBs_DAT_i(wdat),
    .WBs_DAT_o(rdat), .WBs_ACK_o(ack), .M_DATA_o(m_data), .M_VALID_o(m_valid),
    .M_READY_i(m_ready), .IRQ_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    adr = a; wdat = d; bstb = be; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [8:0] a, output logic [31:0] d);
    @(negedge clk);
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    #1 d = rdat;
    @(negedge clk);
    check("read_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0;
  endtask

  // One clock of combined push/ready stimulus checked against the queue model.
  task automatic step(input logic do_wr, input logic [31:0] d, input logic rdy);
    logic will_pop, will_push;
    @(negedge clk);
    m_ready = rdy; adr = A_DATA; wdat = d; bstb = 4'hF;
    we = do_wr; cyc = do_wr; stb = do_wr;
    #1;
    check("stream_valid", 32'(m_valid), 32'(q.size() != 0));
    will_pop  = rdy && (q.size() != 0);
    will_push = do_wr && (q.size() < 16);
    if (will_pop) begin
      check("stream_data", m_data, q[0]);
      void'(q.pop_front());
    end
    if (will_push) q.push_back(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    wb_read(A_STAT, rd); check("status_empty", rd, 32'h0000_0001);
    wb_read(9'h000, rd); check("unmapped", rd, 32'hFABD_EFAC);
    wb_read(A_DATA, rd); check("data_read", rd, 32'h0);

    // Basic push then drain in order
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_write(A_DATA, 32'hA5A5_0001, 4'hF);
    check("latency_valid", 32'(m_valid), 32'd1);
    check("latency_data", m_data, 32'hA5A5_0001);
    wb_write(A_DATA, 32'hA5A5_0002, 4'h0);
    wb_write(A_DATA, 32'hA5A5_0003, 4'hF);
    wb_read(A_STAT, rd); check("status_cnt3", rd, 32'h0000_0300);
    @(negedge clk); m_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("beat_valid", 32'(m_valid), 32'd1);
      check("beat_data", m_data, 32'hA5A5_0000 + 32'(i));
      @(negedge clk);
    end
    check("drained_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    wb_read(A_STAT, rd); check("status_empty2", rd, 32'h0000_0001);

    // Overflow while disabled
    wb_write(A_CTRL, 32'h0, 4'hF);
    for (int i = 0; i < 17; i++) wb_write(A_DATA, 32'hB000_0000 + 32'(i), 4'hF);
    check("disabled_valid", 32'(m_valid), 32'd0);
    wb_read(A_STAT, rd); check("status_ovf", rd, 32'h0000_100E);
    wb_write(A_STAT, 32'h8, 4'h1);
    wb_read(A_STAT, rd); check("status_ovf_clr", rd, 32'h0000_1006);
    wb_read(A_CTRL, rd); check("ctrl_off", rd, 32'h0);
    wb_write(A_CTRL, 32'h1, 4'hF);
    @(negedge clk); m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_beat_valid", 32'(m_valid), 32'd1);
      check("ovf_beat_data", m_data, 32'hB000_0000 + 32'(i));
      @(negedge clk);
    end
    check("ovf_drained", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // Wrap-around with toggling ready
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
      step(1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'hC100_0000 + 32'(i), (i % 3) != 0);
      step(1'b0, 32'h0, (i % 2) != 0);
    end
    for (int k = 0; k < 60 && q.size() != 0; k++) step(1'b0, 32'h0, 1'b1);
    check("wrap_drain_bound", 32'(q.size()), 32'd0);
    step(1'b0, 32'h0, 1'b0);

    // Push while full with a simultaneous pop is dropped
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
      step(1'b0, 32'h0, 1'b0);
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    wb_read(A_STAT, rd); check("status_full_pop", rd, 32'h0000_0F0C);
    for (int k = 0; k < 40 && q.size() != 0; k++) step(1'b0, 32'h0, 1'b1);
    check("full_drain_bound", 32'(q.size()), 32'd0);
    step(1'b0, 32'h0, 1'b0);
    wb_write(A_STAT, 32'h8, 4'h1);

    // Low-watermark interrupt
    wb_write(A_CTRL, 32'h0405, 4'h3);
    check("irq_on", 32'(irq), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wb_write(A_DATA, 32'hE000_0000 + 32'(i), 4'hF);
      check("irq_fill", 32'(irq), (i < 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk); m_ready = 1'b1;
    check("irq_before_pop", 32'(irq), 32'd0);
    @(negedge clk); m_ready = 1'b0;
    check("irq_after_pop", 32'(irq), 32'd1);

    // Flush with concurrent ready
    for (int i = 0; i < 6; i++) wb_write(A_DATA, 32'hF000_0000 + 32'(i), 4'hF);
    wb_read(A_STAT, rd); check("status_cnt10", rd, 32'h0000_0A00);
    @(negedge clk);
    adr = A_CTRL; wdat = 32'h3; bstb = 4'h1; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; m_ready = 1'b0;
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_irq", 32'(irq), 32'd0);
    wb_read(A_STAT, rd); check("flush_status", rd, 32'h0000_0001);
    wb_read(A_CTRL, rd); check("flush_ctrl", rd, 32'h0000_0401);

    // Asynchronous reset mid-stream
    wb_write(A_CTRL, 32'h0405, 4'h3);
    wb_write(A_DATA, 32'h1111_0000, 4'hF);
    wb_write(A_DATA, 32'h1111_0001, 4'hF);
    check("pre_rst_irq", 32'(irq), 32'd1);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    @(negedge clk);
    adr = A_STAT; we = 1'b0; cyc = 1'b1; stb = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    check("async_ack", 32'(ack), 32'd0);
    check("async_valid", 32'(m_valid), 32'd0);
    check("async_irq", 32'(irq), 32'd0);
    cyc = 1'b0; stb = 1'b0; m_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    wb_read(A_STAT, rd); check("post_rst_status", rd, 32'h0000_0001);
    wb_read(A_CTRL, rd); check("post_rst_ctrl", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
